// File: rtl/sample_mem_pkg.sv
// Shared sample-memory definitions: burst geometry, readback FSM states and
// the sample-number to DDR-address mapping used by both capture and readback.
package sample_mem_pkg;

    localparam int unsigned NUM_WORDS_PER_PACKET = 2;
    localparam int unsigned BURST_WORDS          = 8;
    localparam int unsigned SAMPLE_MASK_WIDTH    = 3;
    localparam int unsigned PACKETS_PER_BURST    = BURST_WORDS / NUM_WORDS_PER_PACKET;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_COLLECT,
        ST_DRAIN
    } rd_state_t;

    // Word address of the burst holding a sample (sample x 2, burst-aligned).
    // Callers truncate to their address width, which gives the modulo wrap.
    function automatic logic [31:0] sample_to_word_base(input logic [31:0] sample);
        logic [31:0] word_adx;
        word_adx = {sample[30:0], 1'b0};
        return {word_adx[31:SAMPLE_MASK_WIDTH], {SAMPLE_MASK_WIDTH{1'b0}}};
    endfunction

    // Packet position of a sample inside its burst.
    function automatic logic [1:0] sample_to_offset(input logic [31:0] sample);
        return sample[1:0];
    endfunction

endpackage

// File: rtl/burst_word_buffer.sv
// One DDR burst worth of 16-bit words, read back as a 2-word sample packet.
module burst_word_buffer
    import sample_mem_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [15:0] wr_data,
    input  logic [1:0]  rd_offset,
    output logic [31:0] rd_packet
);

    logic [15:0] words [BURST_WORDS];

    // Capture returned memory words at their position in the burst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    // Packet = {odd word, even word} of the selected pair.
    always_comb begin
        rd_packet = {words[{rd_offset, 1'b1}], words[{rd_offset, 1'b0}]};
    end

endmodule

// File: rtl/adx_to_sample_reader.sv
// Readback engine: turns a (start sample, count) host request into aligned DDR
// burst reads and streams the reassembled 32-bit sample packets to the host.
module adx_to_sample_reader
    import sample_mem_pkg::*;
#(
    parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
    parameter int unsigned ADX_WIDTH           = 27
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_start_sample,
    input  logic [15:0]                    req_count,
    output logic                           mem_rd_req,
    input  logic                           mem_rd_gnt,
    output logic [ADX_WIDTH-1:0]           mem_rd_adx,
    input  logic [15:0]                    mem_rd_data,
    input  logic                           mem_rd_data_valid,
    output logic                           smp_valid,
    input  logic                           smp_ready,
    output logic [SAMPLE_PACKET_WIDTH-1:0] smp_data,
    output logic                           smp_last,
    output logic                           done
);

    rd_state_t                    state;
    logic [15:0]                  remaining;
    logic [1:0]                   offset;
    logic [2:0]                   word_cnt;
    logic [31:0]                  req_word_base;
    logic                         buf_wr_en;
    logic [1:0]                   rd_offset;
    logic [31:0]                  buf_packet;
    logic [SAMPLE_PACKET_WIDTH-1:0] next_packet;

    burst_word_buffer u_buffer (
        .clk       (clk),
        .wr_en     (buf_wr_en),
        .wr_idx    (word_cnt),
        .wr_data   (mem_rd_data),
        .rd_offset (rd_offset),
        .rd_packet (buf_packet)
    );

    // Buffer control and the packet to load into the registered output.
    always_comb begin
        req_word_base = sample_to_word_base(req_start_sample);
        buf_wr_en     = (state == ST_COLLECT) && mem_rd_data_valid;
        // While draining, look one packet ahead so the next beat is ready at the handshake.
        rd_offset     = (state == ST_DRAIN) ? offset + 2'd1 : offset;
        next_packet   = buf_packet;
        // The 8th word is still on the bus when the first packet is loaded;
        // an offset-3 packet takes its odd half straight from it.
        if ((state == ST_COLLECT) && (offset == 2'd3)) begin
            next_packet = {mem_rd_data, buf_packet[15:0]};
        end
    end

    // Request / issue / collect / drain sequencing with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            offset     <= '0;
            word_cnt   <= '0;
            req_ready  <= 1'b1;
            mem_rd_req <= 1'b0;
            mem_rd_adx <= '0;
            smp_valid  <= 1'b0;
            smp_data   <= '0;
            smp_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        mem_rd_adx <= ADX_WIDTH'(req_word_base);
                        offset     <= sample_to_offset(req_start_sample);
                        remaining  <= req_count;
                        if (req_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            req_ready  <= 1'b0;
                            mem_rd_req <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_rd_gnt) begin
                        mem_rd_req <= 1'b0;
                        word_cnt   <= '0;
                        state      <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (mem_rd_data_valid) begin
                        word_cnt <= word_cnt + 3'd1;
                        if (word_cnt == 3'(BURST_WORDS - 1)) begin
                            smp_valid <= 1'b1;
                            smp_data  <= next_packet;
                            smp_last  <= (remaining == 16'd1);
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (smp_ready) begin
                        remaining <= remaining - 16'd1;
                        offset    <= offset + 2'd1;
                        if (remaining == 16'd1) begin
                            smp_valid <= 1'b0;
                            smp_last  <= 1'b0;
                            done      <= 1'b1;
                            req_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else if (offset == 2'(PACKETS_PER_BURST - 1)) begin
                            smp_valid  <= 1'b0;
                            smp_last   <= 1'b0;
                            mem_rd_adx <= mem_rd_adx + ADX_WIDTH'(BURST_WORDS);
                            mem_rd_req <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            smp_data <= next_packet;
                            smp_last <= (remaining == 16'd2);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adx_to_sample_reader.sv
// Directed bench for adx_to_sample_reader with a transaction-level reference model.
module tb_adx_to_sample_reader;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_start_sample;
    logic [15:0] req_count;
    logic        mem_rd_req;
    logic        mem_rd_gnt;
    logic [26:0] mem_rd_adx;
    logic [15:0] mem_rd_data;
    logic        mem_rd_data_valid;
    logic        smp_valid;
    logic        smp_ready;
    logic [31:0] smp_data;
    logic        smp_last;
    logic        done;

    int checks = 0;
    int failures = 0;
    int gnt_delay = 0;
    int stall_beat = -1;
    int stall_cycles = 0;
    int beats = 0;
    int words_sent = 0;

    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic [26:0] exp_base[$];
    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [26:0] got_adx[$];

    adx_to_sample_reader #(
        .SAMPLE_PACKET_WIDTH (32),
        .ADX_WIDTH           (27)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_start_sample  (req_start_sample),
        .req_count         (req_count),
        .mem_rd_req        (mem_rd_req),
        .mem_rd_gnt        (mem_rd_gnt),
        .mem_rd_adx        (mem_rd_adx),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_data_valid (mem_rd_data_valid),
        .smp_valid         (smp_valid),
        .smp_ready         (smp_ready),
        .smp_data          (smp_data),
        .smp_last          (smp_last),
        .done              (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Word address of a sample, modulo the 27-bit DDR address space.
    function automatic logic [26:0] word_of(input logic [31:0] s);
        return 27'(s * 32'd2);
    endfunction

    // Memory model: each word holds the low 16 bits of its own address.
    initial begin : responder
        logic [26:0] badx;
        mem_rd_gnt = 1'b0;
        mem_rd_data_valid = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_rd_req && !reset) begin
                for (int d = 0; d < gnt_delay; d++) begin
                    @(posedge clk); #1;
                end
                mem_rd_gnt = 1'b1;
                badx = mem_rd_adx;
                words_sent = 0;
                @(posedge clk); #1;
                mem_rd_gnt = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    mem_rd_data_valid = 1'b1;
                    mem_rd_data = 16'(badx + 27'(k));
                    words_sent = k + 1;
                    @(posedge clk); #1;
                end
                mem_rd_data_valid = 1'b0;
                mem_rd_data = '0;
            end
        end
    end

    // Consumer: ready except for a programmed stall window at one beat index.
    initial begin : ready_drv
        int stalled;
        stalled = 0;
        smp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (smp_valid && beats == stall_beat && stalled < stall_cycles) begin
                smp_ready = 1'b0;
                stalled++;
            end else begin
                smp_ready = 1'b1;
                if (beats != stall_beat) stalled = 0;
            end
        end
    end

    // Per-cycle comparison against the request-level model.
    initial begin : compare
        logic        done_due;
        logic        req_due;
        logic        hold_chk;
        logic [26:0] held_adx;
        logic [26:0] prev_base;
        logic [26:0] w;
        done_due = 1'b0;
        req_due = 1'b0;
        hold_chk = 1'b0;
        held_adx = '0;
        prev_base = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_data.delete();
                exp_last.delete();
                exp_base.delete();
                done_due = 1'b0;
                req_due = 1'b0;
                hold_chk = 1'b0;
            end else begin
                chk("done", done, done_due);
                if (done_due) chk("ready_with_done", req_ready, 1);
                if (req_due) chk("req_after_accept", mem_rd_req, 1);
                if (hold_chk && mem_rd_req) chk("adx_stable", mem_rd_adx, held_adx);
                done_due = 1'b0;
                req_due = 1'b0;
                chk("one_buffer", mem_rd_req & smp_valid, 0);
                if (mem_rd_req && exp_base.size() == 0) chk("unexpected_req", mem_rd_req, 0);
                if (mem_rd_req && mem_rd_gnt) begin
                    got_adx.push_back(mem_rd_adx);
                    if (exp_base.size() > 0) chk("burst_adx", mem_rd_adx, exp_base.pop_front());
                end
                hold_chk = mem_rd_req && !mem_rd_gnt;
                held_adx = mem_rd_adx;
                if (smp_valid) begin
                    if (exp_data.size() == 0) begin
                        chk("unexpected_smp_valid", smp_valid, 0);
                    end else begin
                        chk("smp_data", smp_data, exp_data[0]);
                        chk("smp_last", smp_last, exp_last[0]);
                        if (smp_ready) begin
                            got_data.push_back(smp_data);
                            got_last.push_back(smp_last);
                            if (exp_last[0]) done_due = 1'b1;
                            void'(exp_data.pop_front());
                            void'(exp_last.pop_front());
                            beats++;
                        end
                    end
                end
                if (req_valid && req_ready) begin
                    got_data.delete();
                    got_last.delete();
                    got_adx.delete();
                    beats = 0;
                    if (req_count == 16'd0) done_due = 1'b1;
                    else req_due = 1'b1;
                    for (int i = 0; i < int'(req_count); i++) begin
                        w = word_of(req_start_sample + 32'(i));
                        exp_data.push_back({16'(w + 27'd1), 16'(w)});
                        exp_last.push_back(i == int'(req_count) - 1);
                        if (i == 0 || (w & ~27'd7) != prev_base) begin
                            prev_base = w & ~27'd7;
                            exp_base.push_back(prev_base);
                        end
                    end
                end
            end
        end
    end

    task automatic run_req(input logic [31:0] start, input logic [15:0] cnt);
        int n;
        @(posedge clk); #1;
        req_start_sample = start;
        req_count = cnt;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", done, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("all_delivered", exp_data.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_rd_req", mem_rd_req, 0);
        chk("rst_mem_rd_adx", mem_rd_adx, 0);
        chk("rst_smp_valid", smp_valid, 0);
        chk("rst_smp_data", smp_data, 0);
        chk("rst_smp_last", smp_last, 0);
        chk("rst_done", done, 0);
    endtask

    initial begin : main
        int n;
        reset = 1'b1;
        req_valid = 1'b0;
        req_start_sample = '0;
        req_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;

        // Two samples from the middle of one burst.
        run_req(32'd5, 16'd2);
        chk("t1_adx0", got_adx[0], 27'd8);
        chk("t1_nbursts", got_adx.size(), 1);
        chk("t1_data0", got_data[0], 32'h000B000A);
        chk("t1_data1", got_data[1], 32'h000D000C);
        chk("t1_last0", got_last[0], 0);
        chk("t1_last1", got_last[1], 1);

        // Crosses a burst boundary.
        run_req(32'd6, 16'd4);
        chk("t2_adx0", got_adx[0], 27'd8);
        chk("t2_adx1", got_adx[1], 27'd16);
        chk("t2_data0", got_data[0], 32'h000D000C);
        chk("t2_data1", got_data[1], 32'h000F000E);
        chk("t2_data2", got_data[2], 32'h00110010);
        chk("t2_data3", got_data[3], 32'h00130012);
        chk("t2_lasts", {got_last[0], got_last[1], got_last[2], got_last[3]}, 4'b0001);

        // Address wraps at the top of the DDR space.
        run_req(32'h03FFFFFF, 16'd2);
        chk("t3_adx0", got_adx[0], 27'h7FFFFF8);
        chk("t3_adx1", got_adx[1], 27'h0000000);
        chk("t3_data0", got_data[0], 32'hFFFFFFFE);
        chk("t3_data1", got_data[1], 32'h00010000);

        // Slow grant and consumer back-pressure mid-burst.
        gnt_delay = 3;
        stall_beat = 1;
        stall_cycles = 5;
        run_req(32'd0, 16'd4);
        gnt_delay = 0;
        stall_beat = -1;
        chk("t4_nbursts", got_adx.size(), 1);
        chk("t4_data1", got_data[1], 32'h00030002);
        chk("t4_data3", got_data[3], 32'h00070006);

        // Empty request.
        run_req(32'd100, 16'd0);
        chk("t5_no_burst", got_adx.size(), 0);
        chk("t5_no_sample", got_data.size(), 0);

        // Reset in the middle of a burst; the rest of that burst arrives afterwards.
        @(posedge clk); #1;
        req_start_sample = 32'd0;
        req_count = 16'd4;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!(mem_rd_data_valid && words_sent == 3) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_third_word", words_sent, 3);
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        while (mem_rd_data_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_stray_idle", {req_ready, mem_rd_req, smp_valid}, 3'b100);
        repeat (2) @(posedge clk);
        run_req(32'd4, 16'd1);
        chk("t6_adx0", got_adx[0], 27'd8);
        chk("t6_data0", got_data[0], 32'h00090008);
        chk("t6_last0", got_last[0], 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adx_to_sample_reader.md
# adx_to_sample_reader

Readback engine for captured logic-analyzer data: takes a host request (start sample number, sample count), issues DDR burst reads at the aligned addresses the capture path used, collects the 16-bit memory words and reassembles 32-bit sample packets. Sits between the DDR read port and the host readback/UART path, with a valid/ready stream towards the host. It is the read-side counterpart of the capture write addressing.

## Interface
- SAMPLE_PACKET_WIDTH, 32, bits per sample packet
- ADX_WIDTH, 27, DDR word-address width
- MEMORY_WORD_WIDTH, 2, bytes per DDR word; packet = 2 words
- BURST_WORDS, 8, words per DDR read burst (= 4 packets)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  host read request
- req_ready  out  1  high only in IDLE
- req_start_sample  in  32  first sample number
- req_count  in  16  number of samples; 0 is legal
- mem_rd_req  out  1  DDR burst read request, held until grant
- mem_rd_gnt  in  1  DDR accepts request this cycle
- mem_rd_adx  out  ADX_WIDTH  burst base word address, 8-aligned
- mem_rd_data  in  16  returned word
- mem_rd_data_valid  in  1  one word per assertion, 8 per burst, in address order
- smp_valid  out  1  sample available
- smp_ready  in  1  consumer accepts
- smp_data  out  SAMPLE_PACKET_WIDTH  {odd word, even word}
- smp_last  out  1  with final sample of request
- done  out  1  one-cycle pulse at request completion

## Operation
- Address rule: word adx = sample×2; burst base = word adx with low 3 bits cleared, truncated to ADX_WIDTH (wraps modulo 2^ADX_WIDTH); in-burst packet offset = sample[1:0].
- Packet packing: even word → smp_data[15:0], odd word → smp_data[31:16].
- States: IDLE, ISSUE, COLLECT, DRAIN.
- IDLE: req_ready=1. On req_valid: latch base, offset, remaining=req_count. count≠0 → ISSUE; count=0 → IDLE, done pulses next cycle, no smp_valid.
- ISSUE: mem_rd_req=1, mem_rd_adx=base stable until mem_rd_gnt; on grant → COLLECT, word counter=0.
- COLLECT: each mem_rd_data_valid writes buffer[word counter], increments it; after 8th word → DRAIN.
- DRAIN: smp_valid=1, smp_data=packet[offset]. On handshake: remaining−1, offset+1. remaining reaches 0 → smp_last was high on that beat, → IDLE, done pulse. Offset passes 3 with remaining>0 → base+8 (wrapping), offset=0, → ISSUE.
- Single burst buffer: no new read issued while DRAIN holds undelivered samples.
- mem_rd_data_valid outside COLLECT is ignored (includes stale data after reset).
- Reset (any state): IDLE, all counters 0, buffer contents don't-care.

## Timing
- Reset values: req_ready=1, mem_rd_req=0, mem_rd_adx=0, smp_valid=0, smp_data=0, smp_last=0, done=0.
- Request accept → mem_rd_req high next cycle.
- Grant cycle → COLLECT next cycle; data accepted from the cycle after grant.
- 8th data word → smp_valid high next cycle.
- smp_data/smp_last stable while smp_valid && !smp_ready.
- Sustained throughput within a burst: 1 sample/cycle with smp_ready=1.
- Final handshake → done=1 next cycle for exactly one cycle; req_ready=1 in that same cycle.
- All outputs registered.

## Structure
- Package sample_mem_pkg: NUM_WORDS_PER_PACKET, BURST_WORDS, SAMPLE_MASK_WIDTH=3, state enum, and the sample→base/offset function shared with the capture side.
- Sub-module burst_word_buffer: 8×16 register file with write-index input and 2-word packet read port selected by offset.

## Test plan
- Start 5, count 2, data words = address value → mem_rd_adx=8 once; samples 0x000B000A, 0x000D000C; smp_last on second; done one cycle later.
- Start 6, count 4 → reads at 8 then 16; samples 0x000D000C, 0x000F000E, 0x00110010, 0x00130012; smp_last only on fourth.
- Start 0x03FFFFFF, count 2 → reads at 0x7FFFFF8 then 0x0000000; no X on mem_rd_adx.
- Start 0, count 4, smp_ready low 5 cycles mid-burst → smp_data held, no new mem_rd_req; mem_rd_gnt delayed 3 cycles → mem_rd_adx stable throughout.
- Count 0 → no mem_rd_req, no smp_valid, done pulse cycle after accept.
- Reset asserted during COLLECT after 3 words, remaining words delivered after reset → outputs at reset values, stray data ignored; next request start 4 count 1 returns correct sample from adx 8.
